// File: rtl/alarm_display_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared definitions for the alarm display controller:
//                active-high seven-segment glyphs ({g,f,e,d,c,b,a}) and
//                the alarm FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package display_pkg;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Alarm FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        ACKED   = 2'd2
    } alarm_state_t;

endpackage : display_pkg
`default_nettype wire

// File: rtl/alarm_display_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_display_ctrl_if
//  Description : Bundle of load/digit/alarm inputs and segment/LED outputs
//                between the clock top level (master) and the display
//                controller (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface alarm_display_ctrl_if #(
    parameter int NUM_DIGITS = 6,
    parameter int NUM_LEDS   = 10
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   bcd_in;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic                      alarm_trigger;
    logic                      alarm_ack;
    logic [7*NUM_DIGITS-1:0]   seg;
    logic [NUM_LEDS-1:0]       leds;
    logic                      alarm_active;

    modport master (
        output load, bcd_in, blink_mask, alarm_trigger, alarm_ack,
        input  seg, leds, alarm_active
    );

    modport slave (
        input  load, bcd_in, blink_mask, alarm_trigger, alarm_ack,
        output seg, leds, alarm_active
    );
endinterface : alarm_display_ctrl_if
`default_nettype wire

// File: rtl/alarm_display_ctrl_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg_encoder
//  Description : Combinational 4-bit code to active-high seven-segment glyph.
//                Codes 0-9 give digits, 10-15 give a dash.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_seg_encoder
    import display_pkg::*;
(
    input  wire logic [3:0] i_code,
    output logic      [6:0] o_glyph
);

    // Glyph lookup
    always_comb begin
        o_glyph = SEG_DASH;
        case (i_code)
            4'd0:    o_glyph = SEG_0;
            4'd1:    o_glyph = SEG_1;
            4'd2:    o_glyph = SEG_2;
            4'd3:    o_glyph = SEG_3;
            4'd4:    o_glyph = SEG_4;
            4'd5:    o_glyph = SEG_5;
            4'd6:    o_glyph = SEG_6;
            4'd7:    o_glyph = SEG_7;
            4'd8:    o_glyph = SEG_8;
            4'd9:    o_glyph = SEG_9;
            default: o_glyph = SEG_DASH;
        endcase
    end

endmodule : bcd_seg_encoder
`default_nettype wire

// File: rtl/alarm_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_display_ctrl
//  Description : Latches NUM_DIGITS BCD digits and drives registered
//                seven-segment outputs with per-digit blinking; runs the
//                alarm FSM with a walking-LED pattern and user acknowledge.
//                Optional macro LEADING_ZERO_BLANK_EN blanks zero digits
//                above the most significant non-zero digit.
//  Revision    : 1.0  initial release
// ============================================================================
module alarm_display_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int NUM_LEDS       = 10,
    parameter int CLK_HZ         = 50_000_000,
    parameter int BLINK_HZ       = 2,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    alarm_display_ctrl_if.slave bus
);

    localparam int c_half_raw = CLK_HZ / (2 * BLINK_HZ);
    localparam int c_half     = (c_half_raw < 1) ? 1 : c_half_raw;
    localparam int c_cnt_w    = (c_half > 1) ? $clog2(c_half) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_half - 1);
    localparam logic [7*NUM_DIGITS-1:0] c_seg_reset =
        (SEG_ACTIVE_LOW != 0) ? {(7*NUM_DIGITS){1'b1}} : {(7*NUM_DIGITS){1'b0}};

    // Registers
    logic [c_cnt_w-1:0]      cnt_q,    cnt_d;
    logic                    phase_q,  phase_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   mask_q,   mask_d;
    logic [7*NUM_DIGITS-1:0] seg_q,    seg_d;
    alarm_state_t            state_q,  state_d;
    logic [NUM_LEDS-1:0]     leds_q,   leds_d;
    logic                    active_q, active_d;
    logic                    trig_prev_q, trig_prev_d;

    logic                    w_tick;
    logic                    w_rise;
    logic [6:0]              w_glyph [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_lz_blank;

    // Prescaler and blink phase; load has no influence here
    always_comb begin
        w_tick  = (cnt_q == c_cnt_last);
        cnt_d   = w_tick ? '0 : cnt_q + c_cnt_w'(1);
        phase_d = phase_q ^ w_tick;
    end

    // Digit and mask capture on load strobe
    always_comb begin
        digits_d = bus.load ? bus.bcd_in     : digits_q;
        mask_d   = bus.load ? bus.blink_mask : mask_q;
    end

    // One glyph encoder per digit
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        bcd_seg_encoder u_enc (
            .i_code  (digits_q[4*gi +: 4]),
            .o_glyph (w_glyph[gi])
        );
    end

    // Leading-zero suppression: a digit is blank when it and every digit above are zero
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic run;
        run        = 1'b1;
        w_lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run           = run & (digits_q[4*i +: 4] == 4'd0);
            w_lz_blank[i] = run && (i != 0);
        end
    end
`else
    always_comb begin
        w_lz_blank = '0;
    end
`endif

    // Final per-digit blanking and polarity, registered next cycle
    always_comb begin
        logic [6:0] g;
        seg_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((mask_q[i] && !phase_q) || w_lz_blank[i]) begin
                g = SEG_BLANK;
            end else begin
                g = w_glyph[i];
            end
            seg_d[7*i +: 7] = (SEG_ACTIVE_LOW != 0) ? ~g : g;
        end
    end

    // Alarm FSM next-state and LED pattern
    always_comb begin
        w_rise      = bus.alarm_trigger && !trig_prev_q;
        trig_prev_d = bus.alarm_trigger;
        state_d     = state_q;
        leds_d      = leds_q;
        active_d    = active_q;
        case (state_q)
            IDLE: begin
                leds_d   = '0;
                active_d = 1'b0;
                if (w_rise) begin
                    state_d  = RINGING;
                    leds_d   = NUM_LEDS'(1);
                    active_d = 1'b1;
                end
            end
            RINGING: begin
                if (!bus.alarm_trigger) begin
                    state_d  = IDLE;
                    leds_d   = '0;
                    active_d = 1'b0;
                end else if (bus.alarm_ack) begin
                    state_d  = ACKED;
                    leds_d   = '0;
                    active_d = 1'b0;
                end else if (w_tick) begin
                    leds_d = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
                end
            end
            ACKED: begin
                leds_d   = '0;
                active_d = 1'b0;
                if (!bus.alarm_trigger) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                leds_d   = '0;
                active_d = 1'b0;
            end
        endcase
    end

    // Display-path registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            phase_q  <= 1'b1;
            digits_q <= '0;
            mask_q   <= '0;
            seg_q    <= c_seg_reset;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            digits_q <= digits_d;
            mask_q   <= mask_d;
            seg_q    <= seg_d;
        end
    end

    // Alarm FSM registers; previous trigger resets high so a held trigger cannot ring
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            leds_q      <= '0;
            active_q    <= 1'b0;
            trig_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            leds_q      <= leds_d;
            active_q    <= active_d;
            trig_prev_q <= trig_prev_d;
        end
    end

    assign bus.seg          = seg_q;
    assign bus.leds         = leds_q;
    assign bus.alarm_active = active_q;

endmodule : alarm_display_ctrl
`default_nettype wire

// File: tb/tb_alarm_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_display_ctrl
//  Description : Self-checking bench for alarm_display_ctrl with a
//                cycle-level behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alarm_display_ctrl;

    localparam int ND   = 6;
    localparam int NL   = 10;
    localparam int HALF = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alarm_display_ctrl_if #(.NUM_DIGITS(ND), .NUM_LEDS(NL)) bus ();

    alarm_display_ctrl #(
        .NUM_DIGITS(ND), .NUM_LEDS(NL), .CLK_HZ(8), .BLINK_HZ(1), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: edges since reset, latched values, alarm mode and LED position
    logic [4*ND-1:0] m_dig;
    logic [ND-1:0]   m_mask;
    logic [7*ND-1:0] m_seg;
    int              m_k;
    int              m_mode;   // 0 idle, 1 ringing, 2 acknowledged
    int              m_pos;
    bit              m_prev;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (c > 4'd9) ? 7'h40 : tbl[c];
    endfunction

    function automatic logic [7*ND-1:0] disp(input logic [4*ND-1:0] d,
                                            input logic [ND-1:0] mk, input int k);
        logic [7*ND-1:0] s;
        bit phase_on;
        bit blank;
        phase_on = ((k / HALF) % 2) == 0;
        for (int i = 0; i < ND; i++) begin
            blank = mk[i] && !phase_on;
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && (d >> (4*i)) == 0) blank = 1;
`endif
            s[7*i +: 7] = blank ? 7'h7F : ~glyph(d[4*i +: 4]);
        end
        return s;
    endfunction

    task automatic model_reset();
        m_dig = '0; m_mask = '0; m_k = 0; m_mode = 0; m_pos = 0; m_prev = 1;
        m_seg = {(7*ND){1'b1}};
    endtask

    task automatic check(input string tag);
        logic [NL-1:0] e_leds;
        e_leds = '0;
        if (m_mode == 1) e_leds[m_pos] = 1'b1;
        n_cmp++;
        assert (bus.seg === m_seg) else begin
            n_bad++;
            $error("FAIL %s seg got %h expected %h", tag, bus.seg, m_seg);
        end
        n_cmp++;
        assert (bus.leds === e_leds) else begin
            n_bad++;
            $error("FAIL %s leds got %h expected %h", tag, bus.leds, e_leds);
        end
        n_cmp++;
        assert (bus.alarm_active === (m_mode == 1)) else begin
            n_bad++;
            $error("FAIL %s active got %b expected %b", tag, bus.alarm_active, m_mode == 1);
        end
    endtask

    // One clock: capture inputs, advance model by the behavioural rules, then check
    task automatic step(input string tag);
        logic ld, trg, ack;
        logic [4*ND-1:0] bcd;
        logic [ND-1:0] mk;
        bit tick, rise;
        ld = bus.load; trg = bus.alarm_trigger; ack = bus.alarm_ack;
        bcd = bus.bcd_in; mk = bus.blink_mask;
        @(posedge clk);
        m_seg = disp(m_dig, m_mask, m_k);
        if (ld) begin m_dig = bcd; m_mask = mk; end
        m_k++;
        tick = (m_k % HALF) == 0;
        rise = trg && !m_prev;
        m_prev = trg;
        case (m_mode)
            0: if (rise) begin m_mode = 1; m_pos = 0; end
            1: if (!trg) m_mode = 0;
               else if (ack) m_mode = 2;
               else if (tick) m_pos = (m_pos + 1) % NL;
            default: if (!trg) m_mode = 0;
        endcase
        #1;
        check(tag);
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic do_load(input logic [4*ND-1:0] b, input logic [ND-1:0] mk);
        bus.load = 1; bus.bcd_in = b; bus.blink_mask = mk;
        step("load");
        bus.load = 0;
    endtask

    initial begin
        logic [6:0] d0, d5;
        bus.load = 0; bus.bcd_in = '0; bus.blink_mask = '0;
        bus.alarm_trigger = 0; bus.alarm_ack = 0;
        model_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 check("reset");
        reset = 0;

        // 1: static digits
        do_load(24'h123456, 6'b0);
        step("show");
        d0 = bus.seg[6:0]; d5 = bus.seg[41:35];
        n_cmp++;
        assert (d0 === 7'b0000010) else begin
            n_bad++; $error("FAIL digit0 got %b expected %b", d0, 7'b0000010);
        end
        n_cmp++;
        assert (d5 === 7'b1111001) else begin
            n_bad++; $error("FAIL digit5 got %b expected %b", d5, 7'b1111001);
        end
        steps(8, "steady");

        // 2: blinking digits 0,1
        do_load(24'h123456, 6'b000011);
        steps(16, "blink");

        // 3: dash for code C
        do_load(24'h12345C, 6'b0);
        step("dash0");
        d0 = bus.seg[6:0];
        n_cmp++;
        assert (d0 === 7'b0111111) else begin
            n_bad++; $error("FAIL dash got %b expected %b", d0, 7'b0111111);
        end

        // 4: ring through a full LED wrap
        bus.alarm_trigger = 1;
        steps(46, "ring");

        // 5: acknowledge, no re-ring, drop and re-raise
        bus.alarm_ack = 1; step("ack"); bus.alarm_ack = 0;
        steps(10, "acked");
        bus.alarm_trigger = 0; steps(3, "drop");
        bus.alarm_trigger = 1; steps(9, "rering");
        // cancel has priority over ack
        bus.alarm_trigger = 0; bus.alarm_ack = 1; step("cancel");
        bus.alarm_ack = 0; steps(2, "idle");
        // ack ignored in idle on the rising-edge cycle
        bus.alarm_trigger = 1; bus.alarm_ack = 1; step("edge_ack");
        bus.alarm_ack = 0; steps(6, "ring2");

        // 6: asynchronous reset mid-ring
        reset = 1;
        #1;
        model_reset();
        check("async_rst");
        @(posedge clk); #1 check("rst_hold");
        reset = 0;
        steps(6, "held_trig");
        bus.alarm_trigger = 0; steps(2, "drop2");
        bus.alarm_trigger = 1; steps(6, "ring3");
        bus.alarm_trigger = 0;
        do_load(24'h000120, 6'b0);
        steps(3, "lzb");

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            bus.load = ($urandom_range(7) == 0);
            bus.bcd_in = 24'($urandom);
            if ($urandom_range(3) == 0) bus.bcd_in[23:12] = '0;
            bus.blink_mask = 6'($urandom);
            if ($urandom_range(9) == 0) bus.alarm_trigger = ~bus.alarm_trigger;
            bus.alarm_ack = ($urandom_range(11) == 0);
            step("rand");
        end
        bus.load = 0; bus.alarm_ack = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_alarm_display_ctrl
`default_nettype wire
